// File: rtl/drum_step_scheduler_if.sv
// Handshake/bus bundle between the drum step scheduler (master) and the
// column datapath / audio FIFO side (slave).
interface drum_step_scheduler_if #(
    parameter int ROW_W  = 6,
    parameter int DATA_W = 18
);
    logic              start;
    logic              strike;
    logic              sample_req;
    logic [DATA_W-1:0] node_val;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  rd_addr_next;
    logic              init_sel;
    logic              we_un;
    logic              we_unm1;
    logic              load_bot;
    logic              shift;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_ready;
    logic [31:0]       step_count;
    logic [15:0]       overrun_cnt;

    modport master (
        input  start, strike, sample_req, node_val, sample_ready,
        output row, rd_addr_next, init_sel, we_un, we_unm1, load_bot, shift,
               sample_out, sample_valid, step_count, overrun_cnt
    );

    modport slave (
        output start, strike, sample_req, node_val, sample_ready,
        input  row, rd_addr_next, init_sel, we_un, we_unm1, load_bot, shift,
               sample_out, sample_valid, step_count, overrun_cnt
    );
endinterface

// File: rtl/drum_step_scheduler.sv
// Per-step row sequencer for the single-column drum datapath.
// Optional feature macro: SCHED_OVERRUN_EN (sample_req-while-busy counter).
module drum_step_scheduler #(
    parameter int NUM_ROW = 33,
    parameter int ROW_W   = 6,
    parameter int DATA_W  = 18,
    parameter int OUT_ROW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    drum_step_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_REQ = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        SHIFT    = 3'd4,
        EMIT     = 3'd5
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW - 1);
    localparam logic [ROW_W-1:0] EMIT_ROW = ROW_W'(OUT_ROW);

    state_t            state_r;
    logic [ROW_W-1:0]  row_r;
    logic              init_sel_r;
    logic              we_un_r;
    logic              we_unm1_r;
    logic              load_bot_r;
    logic              shift_r;
    logic [DATA_W-1:0] sample_out_r;
    logic              sample_valid_r;
    logic [31:0]       step_count_r;
    logic              strike_pend_r;

    // Step sequencer; strobes are set on entry to the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            row_r          <= {ROW_W{1'b0}};
            init_sel_r     <= 1'b1;
            we_un_r        <= 1'b0;
            we_unm1_r      <= 1'b0;
            load_bot_r     <= 1'b0;
            shift_r        <= 1'b0;
            sample_out_r   <= {DATA_W{1'b0}};
            sample_valid_r <= 1'b0;
            step_count_r   <= 32'd0;
            strike_pend_r  <= 1'b0;
        end else begin
            we_un_r    <= 1'b0;
            we_unm1_r  <= 1'b0;
            load_bot_r <= 1'b0;
            shift_r    <= 1'b0;
            if (bus.strike) begin
                strike_pend_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r <= WAIT_REQ;
                    end
                end
                WAIT_REQ: begin
                    if (bus.sample_req) begin
                        state_r       <= READ;
                        row_r         <= {ROW_W{1'b0}};
                        // a strike coinciding with the request is consumed here too
                        if (strike_pend_r || bus.strike) begin
                            init_sel_r <= 1'b1;
                        end
                        strike_pend_r <= 1'b0;
                    end else if (!bus.start) begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    state_r    <= WRITE;
                    we_unm1_r  <= 1'b1;
                    we_un_r    <= (row_r != {ROW_W{1'b0}});
                    load_bot_r <= (row_r == {ROW_W{1'b0}});
                end
                WRITE: begin
                    state_r <= SHIFT;
                    shift_r <= 1'b1;
                    if (row_r == EMIT_ROW) begin
                        sample_out_r <= bus.node_val;
                    end
                end
                SHIFT: begin
                    if (row_r == LAST_ROW) begin
                        row_r          <= {ROW_W{1'b0}};
                        init_sel_r     <= 1'b0;
                        step_count_r   <= step_count_r + 32'd1;
                        sample_valid_r <= 1'b1;
                        state_r        <= EMIT;
                    end else begin
                        row_r   <= row_r + ROW_W'(1);
                        state_r <= READ;
                    end
                end
                EMIT: begin
                    if (bus.sample_ready) begin
                        sample_valid_r <= 1'b0;
                        state_r        <= bus.start ? WAIT_REQ : IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_OVERRUN_EN
    logic        busy_s;
    logic [15:0] overrun_r;

    // Busy means a step is in flight or its sample is still unaccepted
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            READ, WRITE, SHIFT, EMIT: busy_s = 1'b1;
            default:                  busy_s = 1'b0;
        endcase
    end

    // Saturating count of requests the scheduler had to drop
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 16'd0;
        end else if (bus.sample_req && busy_s && (overrun_r != 16'hFFFF)) begin
            overrun_r <= overrun_r + 16'd1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.overrun_cnt = overrun_r;
`else
    assign bus.overrun_cnt = 16'h0000;
`endif

    assign bus.rd_addr_next = (row_r == LAST_ROW) ? {ROW_W{1'b0}} : (row_r + ROW_W'(1));
    assign bus.row          = row_r;
    assign bus.init_sel     = init_sel_r;
    assign bus.we_un        = we_un_r;
    assign bus.we_unm1      = we_unm1_r;
    assign bus.load_bot     = load_bot_r;
    assign bus.shift        = shift_r;
    assign bus.sample_out   = sample_out_r;
    assign bus.sample_valid = sample_valid_r;
    assign bus.step_count   = step_count_r;
endmodule

// File: tb/tb_drum_step_scheduler.sv
// Self-checking bench for drum_step_scheduler: scoreboarded samples, row/strobe
// walk, strike re-seeding, EMIT back-pressure, stop and reset mid-step.
module tb_drum_step_scheduler;
    localparam int NUM_ROW = 33;
    localparam int ROW_W   = 6;
    localparam int DATA_W  = 18;
    localparam int OUT_ROW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    drum_step_scheduler_if #(.ROW_W(ROW_W), .DATA_W(DATA_W)) bus ();

    logic [DATA_W-1:0] node_base;
    logic [DATA_W-1:0] node_slope;
    // Stand-in compute node: value depends on the row so the capture row is visible
    assign bus.node_val = node_base + DATA_W'(bus.row) * node_slope;

    drum_step_scheduler #(
        .NUM_ROW(NUM_ROW), .ROW_W(ROW_W), .DATA_W(DATA_W), .OUT_ROW(OUT_ROW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [31:0]       exp_steps;
    logic [15:0]       exp_ovr;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one step from WAIT_REQ through the EMIT handshake, checking as it goes
    task automatic do_step(input bit exp_init, input int strike_at, input int stop_at,
                           input int stall_cycles);
        int                lat   = 0;
        int                wcnt  = 0;
        int                scnt  = 0;
        int                lbcnt = 0;
        bit                done  = 1'b0;
        logic [ROW_W-1:0]  exp_next;
        logic [DATA_W-1:0] held;
        logic [DATA_W-1:0] expv;
        exp_q.push_back(DATA_W'(node_base + DATA_W'(OUT_ROW) * node_slope));
        bus.sample_req = 1'b1;
        bus.strike     = (strike_at == 0);
        while (!done && lat < 500) begin
            tick();
            lat++;
            bus.sample_req = 1'b0;
            bus.strike     = (lat == strike_at);
            if (lat == stop_at) bus.start = 1'b0;
            exp_next = (bus.row == ROW_W'(NUM_ROW - 1)) ? {ROW_W{1'b0}} : bus.row + ROW_W'(1);
            n_cmp++;
            if (bus.rd_addr_next !== exp_next) begin
                n_bad++;
                $display("FAIL rd_addr_next: got %0d want %0d", bus.rd_addr_next, exp_next);
            end
            if (bus.we_unm1 === 1'b1) begin
                n_cmp++;
                if (bus.row !== ROW_W'(wcnt) || bus.we_un !== (wcnt != 0) ||
                    bus.load_bot !== (wcnt == 0) || bus.init_sel !== exp_init) begin
                    n_bad++;
                    $display("FAIL write_row: got row=%0d we_un=%b load_bot=%b init_sel=%b want row=%0d we_un=%b load_bot=%b init_sel=%b",
                             bus.row, bus.we_un, bus.load_bot, bus.init_sel,
                             wcnt, (wcnt != 0), (wcnt == 0), exp_init);
                end
                wcnt++;
            end
            if (bus.shift === 1'b1) scnt++;
            if (bus.load_bot === 1'b1) lbcnt++;
            if (bus.sample_valid === 1'b1) done = 1'b1;
        end
        bus.strike = 1'b0;
        n_cmp++;
        if (!done || lat != 3 * NUM_ROW + 1) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles (valid=%b) want %0d", lat, done, 3 * NUM_ROW + 1);
        end
        n_cmp++;
        if (wcnt != NUM_ROW || scnt != NUM_ROW || lbcnt != 1) begin
            n_bad++;
            $display("FAIL strobe_count: got we=%0d shift=%0d load_bot=%0d want %0d/%0d/1",
                     wcnt, scnt, lbcnt, NUM_ROW, NUM_ROW);
        end
        exp_steps++;
        n_cmp++;
        if (bus.step_count !== exp_steps || bus.init_sel !== 1'b0) begin
            n_bad++;
            $display("FAIL step_end: got step_count=%0d init_sel=%b want %0d/0",
                     bus.step_count, bus.init_sel, exp_steps);
        end
        expv = exp_q.pop_front();
        n_cmp++;
        if (bus.sample_out !== expv) begin
            n_bad++;
            $display("FAIL sample_out: got %h want %h", bus.sample_out, expv);
        end
        held = bus.sample_out;
        for (int i = 0; i < stall_cycles; i++) begin
            bus.sample_req = 1'b1;
            tick();
            n_cmp++;
            if (bus.sample_valid !== 1'b1 || bus.sample_out !== held ||
                bus.we_unm1 !== 1'b0 || bus.shift !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold: got valid=%b out=%h we_unm1=%b shift=%b want 1/%h/0/0",
                         bus.sample_valid, bus.sample_out, bus.we_unm1, bus.shift, held);
            end
        end
`ifdef SCHED_OVERRUN_EN
        exp_ovr = exp_ovr + 16'(stall_cycles);
`endif
        bus.sample_req   = 1'b0;
        bus.sample_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.sample_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL handshake: got valid=%b want 0", bus.sample_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.row !== 6'd0 || bus.init_sel !== 1'b1 || bus.we_un !== 1'b0 ||
            bus.we_unm1 !== 1'b0 || bus.load_bot !== 1'b0 || bus.shift !== 1'b0 ||
            bus.sample_valid !== 1'b0 || bus.sample_out !== 18'h00000 ||
            bus.step_count !== 32'd0 || bus.overrun_cnt !== 16'd0 || bus.rd_addr_next !== 6'd1) begin
            n_bad++;
            $display("FAIL reset_state: got row=%0d init=%b we=%b%b lb=%b sh=%b v=%b out=%h sc=%0d ov=%0d nxt=%0d want 0/1/00/0/0/0/0/0/0/1",
                     bus.row, bus.init_sel, bus.we_un, bus.we_unm1, bus.load_bot, bus.shift,
                     bus.sample_valid, bus.sample_out, bus.step_count, bus.overrun_cnt, bus.rd_addr_next);
        end
        rst       = 1'b0;
        exp_steps = 32'd0;
        exp_ovr   = 16'd0;
    endtask

    task automatic test_first_step;
        bus.start  = 1'b1;
        node_base  = 18'h01234;
        node_slope = 18'h00000;
        tick();
        tick();
        do_step(1'b1, -1, -1, 0);
    endtask

    task automatic test_back_to_back;
        node_base  = 18'h00100;
        node_slope = 18'h00001;
        do_step(1'b0, -1, -1, 0);
        node_base  = 18'h3FF00;
        node_slope = 18'h00003;
        do_step(1'b0, -1, -1, 0);
    endtask

    task automatic test_strike;
        node_base  = 18'h2AAAA;
        node_slope = 18'h00011;
        do_step(1'b0, 30, -1, 0);
        do_step(1'b1, -1, -1, 0);
        do_step(1'b0, -1, -1, 0);
        do_step(1'b1, 0, -1, 0);
        do_step(1'b0, -1, -1, 0);
    endtask

    task automatic test_emit_stall;
        node_base        = 18'h15555;
        node_slope       = 18'h00101;
        bus.sample_ready = 1'b0;
        do_step(1'b0, -1, -1, 10);
        n_cmp++;
        if (bus.overrun_cnt !== exp_ovr) begin
            n_bad++;
            $display("FAIL overrun_cnt: got %0d want %0d", bus.overrun_cnt, exp_ovr);
        end
    endtask

    task automatic test_stop_mid_step;
        bit seen = 1'b0;
        node_base  = 18'h00777;
        node_slope = 18'h00002;
        do_step(1'b0, -1, 40, 0);
        bus.sample_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.sample_req = 1'b0;
            if (bus.we_unm1 === 1'b1 || bus.shift === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL stop_idle: got strobes after stop want none");
        end
        bus.start = 1'b1;
        tick();
        tick();
        do_step(1'b0, -1, -1, 0);
    endtask

    task automatic test_reset_mid_step;
        int n = 0;
        bus.sample_req = 1'b1;
        tick();
        bus.sample_req = 1'b0;
        while (!(bus.we_un === 1'b1 && bus.row === 6'd10) && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 200) begin
            n_bad++;
            $display("FAIL reach_row10: got timeout want WRITE at row 10");
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.we_un !== 1'b0 || bus.we_unm1 !== 1'b0 || bus.row !== 6'd0 ||
            bus.step_count !== 32'd0 || bus.shift !== 1'b0 || bus.init_sel !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: got we=%b%b row=%0d sc=%0d sh=%b init=%b want 00/0/0/0/1",
                     bus.we_un, bus.we_unm1, bus.row, bus.step_count, bus.shift, bus.init_sel);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_steps  = 32'd0;
        exp_ovr    = 16'd0;
        node_base  = 18'h0ABCD;
        node_slope = 18'h00000;
        tick();
        tick();
        do_step(1'b1, -1, -1, 0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.strike       = 1'b0;
        bus.sample_req   = 1'b0;
        bus.sample_ready = 1'b1;
        node_base        = 18'h00000;
        node_slope       = 18'h00000;
        exp_steps        = 32'd0;
        exp_ovr          = 16'd0;
        test_reset();
        test_first_step();
        test_back_to_back();
        test_strike();
        test_emit_stall();
        test_stop_mid_step();
        test_reset_mid_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end
endmodule
